// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcodes and default memory geometry.
// Imported by both the SPI slave and the RAM controller.
package spi_pkg;

  // Command opcode carried in rx_data[9:8]
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } spi_op_e;

  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam int unsigned DEF_ADDR_SIZE = 8;

endpackage : spi_pkg

// File: rtl/sp_ram_array.sv
// Plain single-port byte array: synchronous write, combinational read of the
// same address. No reset, so contents survive a controller reset.
module sp_ram_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem_q [DEPTH];

  // Write port: store din at addr on a write-enabled rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  // Read port: the word at addr is available in the same cycle so the
  // controller can capture it on the command edge
  assign dout = mem_q[addr];

endmodule : sp_ram_array

// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM sitting behind the SPI slave.
// Each rx_valid cycle is one command; the write and read address registers
// share the one RAM port, selected by the opcode being decoded.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [9:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       err
);

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_vld_q, wr_addr_vld_d;
  logic                 rd_addr_vld_q, rd_addr_vld_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;

  logic                 ram_we_s;
  logic [ADDR_SIZE-1:0] ram_addr_s;
  logic [7:0]           ram_dout_s;
  spi_op_e              op_s;

  assign op_s = spi_op_e'(rx_data[9:8]);

  sp_ram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .din  (rx_data[7:0]),
    .dout (ram_dout_s)
  );

  // Decode one command per rx_valid cycle and steer the single RAM port
  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    err_d         = err_q;
    ram_we_s      = 1'b0;
    ram_addr_s    = wr_addr_q;

    if (rx_valid) begin
      case (op_s)
        OP_WR_ADDR: begin
          wr_addr_d     = rx_data[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
        end
        OP_WR_DATA: begin
          ram_addr_s = wr_addr_q;
          if (wr_addr_vld_q) begin
            ram_we_s = 1'b1;
            // Depth is 2**ADDR_SIZE, so natural overflow is the wrap
            if (AUTO_INC != 0) begin
              wr_addr_d = wr_addr_q + ADDR_SIZE'(1'b1);
            end else begin
              wr_addr_d = wr_addr_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d     = rx_data[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
        end
        OP_RD_DATA: begin
          ram_addr_s = rd_addr_q;
          if (rd_addr_vld_q) begin
            tx_data_d  = ram_dout_s;
            tx_valid_d = 1'b1;
            if (AUTO_INC != 0) begin
              rd_addr_d = rd_addr_q + ADDR_SIZE'(1'b1);
            end else begin
              rd_addr_d = rd_addr_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          ram_addr_s = wr_addr_q;
        end
      endcase
    end else begin
      ram_addr_s = wr_addr_q;
    end
  end

  // Control and output registers; RAM contents are deliberately not reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      err_q         <= err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule : spi_ram_ctrl

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (AUTO_INC=0 and AUTO_INC=1) share
// one command stream and are each checked against a behavioural model,
// plus a vector table and hand-written corner-case sequences.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       err0, err1;

  int n_cmp;
  int n_err;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .err(err0)
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int         m_wa   [2];
  int         m_ra   [2];
  bit         m_wv   [2];
  bit         m_rv   [2];
  bit         m_err  [2];
  bit         m_txv  [2];
  logic [7:0] m_txd  [2];
  logic [7:0] m_mem  [2][256];
  logic [7:0] fill_val [256];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 0; m_ra[k] = 0; m_wv[k] = 0; m_rv[k] = 0;
      m_err[k] = 0; m_txv[k] = 0; m_txd[k] = 8'h00;
    end
  endtask

  task automatic model_step(input logic v, input logic [9:0] d);
    for (int k = 0; k < 2; k++) begin
      m_txv[k] = 0;
      if (v) begin
        if (d[9:8] == 2'd0) begin
          m_wa[k] = int'(d[7:0]); m_wv[k] = 1;
        end else if (d[9:8] == 2'd1) begin
          if (m_wv[k]) begin
            m_mem[k][m_wa[k]] = d[7:0];
            if (k == 1) m_wa[k] = (m_wa[k] + 1) % 256;
          end else m_err[k] = 1;
        end else if (d[9:8] == 2'd2) begin
          m_ra[k] = int'(d[7:0]); m_rv[k] = 1;
        end else begin
          if (m_rv[k]) begin
            m_txd[k] = m_mem[k][m_ra[k]];
            m_txv[k] = 1;
            if (k == 1) m_ra[k] = (m_ra[k] + 1) % 256;
          end else m_err[k] = 1;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input bit txv, input logic [7:0] txd, input bit e, input string tag);
    if (k == 0) begin
      check({tag, " dut0.tx_valid"}, {7'd0, tx_valid0}, {7'd0, txv});
      check({tag, " dut0.tx_data"},  tx_data0, txd);
      check({tag, " dut0.err"},      {7'd0, err0}, {7'd0, e});
    end else begin
      check({tag, " dut1.tx_valid"}, {7'd0, tx_valid1}, {7'd0, txv});
      check({tag, " dut1.tx_data"},  tx_data1, txd);
      check({tag, " dut1.err"},      {7'd0, err1}, {7'd0, e});
    end
  endtask

  // One command cycle: drive at negedge, advance model at posedge, compare
  task automatic cycle(input logic v, input logic [9:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_dut(0, m_txv[0], m_txd[0], m_err[0], "model");
    check_dut(1, m_txv[1], m_txd[1], m_err[1], "model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       txv;
    logic [7:0] txd;
    logic       e;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [1:0] op;
    n_cmp = 0;
    n_err = 0;

    // Write/read of 0x2A followed by a 5-cycle idle gap
    tbl[0] = '{1'b1, {2'b00, 8'h2A}, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, {2'b01, 8'hC5}, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, {2'b10, 8'h2A}, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, {2'b11, 8'h9E}, 1'b1, 8'hC5, 1'b0};
    for (int i = 4; i < 9; i++) tbl[i] = '{1'b0, 10'h3FF, 1'b0, 8'hC5, 1'b0};

    rx_valid = 1'b0;
    rx_data  = 10'h000;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dut(0, 1'b0, 8'h00, 1'b0, "reset");
    check_dut(1, 1'b0, 8'h00, 1'b0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every location with a known random byte in both instances
    for (int a = 0; a < 256; a++) begin
      fill_val[a] = 8'($urandom);
      cycle(1'b1, {2'b00, 8'(a)});
      cycle(1'b1, {2'b01, fill_val[a]});
    end

    // Table-driven write/read and idle-gap hold
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].d);
      check_dut(0, tbl[i].txv, tbl[i].txd, tbl[i].e, $sformatf("tbl%0d", i));
      check_dut(1, tbl[i].txv, tbl[i].txd, tbl[i].e, $sformatf("tbl%0d", i));
    end

    // Persistence data, then a read whose result is cut by an async reset
    cycle(1'b1, {2'b00, 8'h10});
    cycle(1'b1, {2'b01, 8'h5A});
    cycle(1'b1, {2'b10, 8'h2A});
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(0, 1'b1, 8'hC5, 1'b0, "pre-reset read");
    #2;
    rst_n = 1'b0;
    #1;
    check_dut(0, 1'b0, 8'h00, 1'b0, "async reset");
    check_dut(1, 1'b0, 8'h00, 1'b0, "async reset");
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Write with no write address: error, then read with no read address
    cycle(1'b1, {2'b01, 8'h11});
    check_dut(0, 1'b0, 8'h00, 1'b1, "err wr");
    check_dut(1, 1'b0, 8'h00, 1'b1, "err wr");
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(0, 1'b0, 8'h00, 1'b1, "err rd");
    check_dut(1, 1'b0, 8'h00, 1'b1, "err rd");

    // Data written before reset survives it
    cycle(1'b1, {2'b10, 8'h10});
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(0, 1'b1, 8'h5A, 1'b1, "persist");
    check_dut(1, 1'b1, 8'h5A, 1'b1, "persist");

    // Location 0 was not touched by the rejected write
    cycle(1'b1, {2'b10, 8'h00});
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(0, 1'b1, fill_val[0], 1'b1, "mem0 kept");
    check_dut(1, 1'b1, fill_val[0], 1'b1, "mem0 kept");

    // Auto-increment wrap from 0xFF to 0x00
    do_reset();
    cycle(1'b1, {2'b00, 8'hFF});
    cycle(1'b1, {2'b01, 8'hA1});
    cycle(1'b1, {2'b01, 8'hB2});
    cycle(1'b1, {2'b10, 8'hFF});
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(1, 1'b1, 8'hA1, 1'b0, "wrap rd1");
    check_dut(0, 1'b1, 8'hB2, 1'b0, "noinc rd1");
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(1, 1'b1, 8'hB2, 1'b0, "wrap rd2");
    check_dut(0, 1'b1, 8'hB2, 1'b0, "noinc rd2");
    cycle(1'b0, 10'h000);
    check_dut(1, 1'b0, 8'hB2, 1'b0, "wrap idle");
    cycle(1'b1, {2'b10, 8'h00});
    cycle(1'b1, {2'b11, 8'h00});
    check_dut(1, 1'b1, 8'hB2, 1'b0, "wrap mem0");

    // Randomized command stream against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      op = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 3) != 0), {op, 8'($urandom)});
      if (i == 400) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_ram_ctrl
